// File: rtl/uart_text_ctrl_if.sv
// Bundles the UART byte intake, the text-buffer write port and the
// cursor/status outputs of the UART text controller.
interface uart_text_ctrl_if #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
  logic          wr_ready_i;
  logic [RW-1:0] cursor_row_o;
  logic [CW-1:0] cursor_col_o;
  logic          busy_o;
  logic          overrun_o;
  logic          ovr_clr_i;

  modport master (
    input  rx_valid_i, rx_data_i, wr_ready_i, ovr_clr_i,
    output wr_valid_o, wr_addr_o, wr_data_o,
           cursor_row_o, cursor_col_o, busy_o, overrun_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, wr_ready_i, ovr_clr_i,
    input  wr_valid_o, wr_addr_o, wr_data_o,
           cursor_row_o, cursor_col_o, busy_o, overrun_o
  );
endinterface

// File: rtl/uart_text_ctrl.sv
// Turns the UART byte stream into text-buffer writes, cursor moves and a
// full-screen clear, with a one-byte holding slot while a write is in flight.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | decode next byte (held byte first, then a fresh one)
// S_WRITE   | one character write outstanding on the buffer port
// S_ESC_ROW | next byte is the cursor row (clamped)
// S_ESC_COL | next byte is the cursor column (clamped)
// S_CLEAR   | sweeping 0x20 over every cell, ascending address
module uart_text_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  uart_text_ctrl_if.master bus
);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_ESC_ROW, S_ESC_COL, S_CLEAR
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic [7:0]    pend_data, pend_data_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [7:0]    data, data_nxt;
  logic          ovr, ovr_nxt;
  logic          drop;
  logic          byte_vld;
  logic [7:0]    byte_cur;
  logic [AW-1:0] cur_addr;

  assign cur_addr = AW'(row) * AW'(COLS) + AW'(col);

  // A held byte always goes ahead of a freshly received one.
  assign byte_vld = pend_vld | bus.rx_valid_i;
  assign byte_cur = pend_vld ? pend_data : bus.rx_data_i;

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    col_nxt       = col;
    pend_vld_nxt  = pend_vld;
    pend_data_nxt = pend_data;
    addr_nxt      = addr;
    data_nxt      = data;
    drop          = 1'b0;

    if (state == S_WRITE || state == S_CLEAR) begin
      if (bus.rx_valid_i) begin
        if (pend_vld) begin
          drop = 1'b1;
        end else begin
          pend_vld_nxt  = 1'b1;
          pend_data_nxt = bus.rx_data_i;
        end
      end
    end else if (pend_vld) begin
      pend_vld_nxt  = bus.rx_valid_i;
      pend_data_nxt = bus.rx_valid_i ? bus.rx_data_i : pend_data;
    end

    unique case (state)
      S_IDLE: begin
        if (byte_vld) begin
          if (byte_cur >= 8'h20 && byte_cur <= 8'h7E) begin
            state_nxt = S_WRITE;
            addr_nxt  = cur_addr;
            data_nxt  = byte_cur;
          end else begin
            case (byte_cur)
              8'h0D: col_nxt = '0;
              8'h0A: begin
                col_nxt = '0;
                row_nxt = (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
              end
              8'h08: if (col != '0) col_nxt = col - CW'(1);
              8'h1B: state_nxt = S_ESC_ROW;
              8'h0C: begin
                state_nxt = S_CLEAR;
                addr_nxt  = '0;
                data_nxt  = 8'h20;
              end
              default: ;
            endcase
          end
        end
      end
      S_ESC_ROW: begin
        if (byte_vld) begin
          row_nxt   = (32'(byte_cur) >= 32'(ROWS)) ? RW'(ROWS-1) : RW'(byte_cur);
          state_nxt = S_ESC_COL;
        end
      end
      S_ESC_COL: begin
        if (byte_vld) begin
          col_nxt   = (32'(byte_cur) >= 32'(COLS)) ? CW'(COLS-1) : CW'(byte_cur);
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (bus.wr_ready_i) begin
          state_nxt = S_IDLE;
          if (col == CW'(COLS-1)) begin
            col_nxt = '0;
            row_nxt = (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
          end else begin
            col_nxt = col + CW'(1);
          end
        end
      end
      S_CLEAR: begin
        if (bus.wr_ready_i) begin
          if (addr == AW'(CELLS-1)) begin
            state_nxt = S_IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
          end else begin
            addr_nxt = addr + AW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ovr_nxt = drop ? 1'b1 : (bus.ovr_clr_i ? 1'b0 : ovr);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      addr      <= '0;
      data      <= '0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_data <= pend_data_nxt;
      addr      <= addr_nxt;
      data      <= data_nxt;
      ovr       <= ovr_nxt;
    end
  end

  assign bus.wr_valid_o   = (state == S_WRITE) || (state == S_CLEAR);
  assign bus.busy_o       = (state == S_WRITE) || (state == S_CLEAR);
  assign bus.wr_addr_o    = addr;
  assign bus.wr_data_o    = data;
  assign bus.cursor_row_o = row;
  assign bus.cursor_col_o = col;
  assign bus.overrun_o    = ovr;
endmodule

// File: tb/tb_uart_text_ctrl.sv
// Directed and randomized checks of uart_text_ctrl against a linear-address
// reference model of the screen cursor and the expected write stream.
module tb_uart_text_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW   = 12;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 1;  // 0 low, 1 high, 2 random

  uart_text_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) bus ();

  uart_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [AW+7:0] exp_q[$];
  int m_row = 0, m_col = 0, m_esc = 0;

  task automatic m_advance();
    int p;
    p = (m_row * COLS + m_col + 1) % (COLS * ROWS);
    m_row = p / COLS;
    m_col = p % COLS;
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (m_esc == 1) begin
      m_row = (int'(b) > ROWS - 1) ? ROWS - 1 : int'(b);
      m_esc = 2;
    end else if (m_esc == 2) begin
      m_col = (int'(b) > COLS - 1) ? COLS - 1 : int'(b);
      m_esc = 0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({AW'(m_row * COLS + m_col), b});
      m_advance();
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        8'h08: if (m_col > 0) m_col = m_col - 1;
        8'h1B: m_esc = 1;
        8'h0C: begin
          for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back({AW'(i), 8'h20});
          m_row = 0;
          m_col = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, 32'(bus.cursor_row_o), 32'(m_row));
    check({tag, "_col"}, 32'(bus.cursor_col_o), 32'(m_col));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    @(posedge clk); #2;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    bus.ovr_clr_i  = clr;
    @(posedge clk); #2;
    bus.rx_valid_i = 1'b0;
    bus.ovr_clr_i  = 1'b0;
  endtask

  task automatic send_m(input logic [7:0] b);
    send_byte(b, 1'b0);
    m_apply(b);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 20000 && quiet < 3; i++) begin
      @(negedge clk);
      if (bus.busy_o) quiet = 0;
      else quiet++;
    end
    checks++;
    assert (quiet >= 3) else begin
      errors++;
      $error("FAIL wait_idle: observed=busy expected=idle");
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.wr_ready_i = 1'b0;
      1:       bus.wr_ready_i = 1'b1;
      default: bus.wr_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // write-port monitor: ordering, hold-while-stalled, valid only when busy
  logic          stall_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_data;
  logic [AW+7:0] exp_w;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        assert (bus.wr_valid_o === 1'b1 && bus.wr_addr_o === prev_addr &&
                bus.wr_data_o === prev_data) else begin
          errors++;
          $error("FAIL hold_stable: observed=%0b/%0h/%0h expected=1/%0h/%0h",
                 bus.wr_valid_o, bus.wr_addr_o, bus.wr_data_o, prev_addr, prev_data);
        end
      end
      if (bus.wr_valid_o === 1'b1) begin
        checks++;
        assert (bus.busy_o === 1'b1) else begin
          errors++;
          $error("FAIL valid_busy: observed busy=%0b expected=1", bus.busy_o);
        end
      end
      if (bus.wr_valid_o === 1'b1 && bus.wr_ready_i === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr=%0d data=%0h expected=none",
                 bus.wr_addr_o, bus.wr_data_o);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          checks++;
          assert ({bus.wr_addr_o, bus.wr_data_o} === exp_w) else begin
            errors++;
            $error("FAIL write: observed addr=%0d data=%0h expected addr=%0d data=%0h",
                   bus.wr_addr_o, bus.wr_data_o, exp_w[AW+7:8], exp_w[7:0]);
          end
        end
      end
      stall_prev = bus.wr_valid_o && !bus.wr_ready_i;
      prev_addr  = bus.wr_addr_o;
      prev_data  = bus.wr_data_o;
    end
  end

  initial begin
    int sel;
    logic [7:0] b;
    rstn           = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.ovr_clr_i  = 1'b0;
    bus.wr_ready_i = 1'b1;
    #12;
    check("rst_valid",   32'(bus.wr_valid_o),   0);
    check("rst_addr",    32'(bus.wr_addr_o),    0);
    check("rst_data",    32'(bus.wr_data_o),    0);
    check("rst_row",     32'(bus.cursor_row_o), 0);
    check("rst_col",     32'(bus.cursor_col_o), 0);
    check("rst_busy",    32'(bus.busy_o),       0);
    check("rst_overrun", 32'(bus.overrun_o),    0);
    @(negedge clk);
    rstn = 1'b1;

    // single character, one-cycle latency
    ready_mode = 1;
    send_m(8'h41);
    @(negedge clk);
    check("a_valid", 32'(bus.wr_valid_o), 1);
    check("a_addr",  32'(bus.wr_addr_o),  0);
    check("a_data",  32'(bus.wr_data_o),  32'h41);
    @(negedge clk);
    check("a_valid_drop", 32'(bus.wr_valid_o), 0);
    check_cursor("a_cursor");

    // positioning and line/screen wrap
    send_m(8'h1B); send_m(8'd5); send_m(8'd79); send_m(8'h5A);
    wait_idle();
    check_cursor("wrap_line");
    check("wrap_line_row6", 32'(bus.cursor_row_o), 6);
    send_m(8'h1B); send_m(8'd29); send_m(8'd79); send_m(8'h58);
    wait_idle();
    check_cursor("wrap_screen");

    // clamping, CR, BS at column 0
    send_m(8'h1B); send_m(8'd200); send_m(8'd200);
    wait_idle();
    check_cursor("clamp");
    check("clamp_row29", 32'(bus.cursor_row_o), 29);
    send_m(8'h0D);
    wait_idle();
    check_cursor("cr");
    send_m(8'h08);
    wait_idle();
    check_cursor("bs_col0");
    check("bs_no_write", 32'(exp_q.size()), 0);

    // clear with stalls
    ready_mode = 2;
    send_m(8'h0C);
    wait_idle();
    check_cursor("clear");
    check("clear_all_written", 32'(exp_q.size()), 0);

    // bytes during clear: one held, later ones dropped
    send_m(8'h0C);
    send_m(8'h78);
    send_byte(8'h79, 1'b1);
    @(negedge clk);
    check("ovr_set_wins", 32'(bus.overrun_o), 1);
    send_byte(8'h7A, 1'b0);
    wait_idle();
    check_cursor("held_byte");
    check("held_written", 32'(exp_q.size()), 0);
    check("ovr_sticky", 32'(bus.overrun_o), 1);
    @(posedge clk); #2;
    bus.ovr_clr_i = 1'b1;
    @(posedge clk); #2;
    bus.ovr_clr_i = 1'b0;
    @(negedge clk);
    check("ovr_clear", 32'(bus.overrun_o), 0);

    // randomized byte stream, spaced so nothing is dropped
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 10);
      if (sel <= 5)       b = 8'($urandom_range(32, 126));
      else if (sel == 6)  b = 8'h0D;
      else if (sel == 7)  b = 8'h0A;
      else if (sel == 8)  b = 8'h08;
      else if (sel == 9)  b = 8'h1B;
      else                b = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'($urandom_range(128, 255));
      send_m(b);
      if (b == 8'h1B) begin
        send_m(8'($urandom_range(0, 255)));
        send_m(8'($urandom_range(0, 255)));
      end
      wait_idle();
      check_cursor("rand");
    end
    check("rand_all_written", 32'(exp_q.size()), 0);
    check("rand_no_overrun", 32'(bus.overrun_o), 0);

    // asynchronous reset while a write is stalled
    ready_mode = 0;
    send_byte(8'h51, 1'b0);
    @(negedge clk);
    check("stall_valid", 32'(bus.wr_valid_o), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_valid", 32'(bus.wr_valid_o), 0);
    check("async_busy",  32'(bus.busy_o),     0);
    repeat (2) @(negedge clk);
    rstn  = 1'b1;
    m_row = 0;
    m_col = 0;
    m_esc = 0;
    @(negedge clk);
    check_cursor("post_reset");
    check("post_reset_busy", 32'(bus.busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
